// File: rtl/pipe_pkg.sv
// Shared definitions for the E->M pipeline slice chain.
// Holds the default field widths, the default payload layout, and the saturating Tnew decrement.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_TNEW_W = 2;
  localparam int DEF_CTRL_W = 2;

  // Widest Tnew the shared decrement helper can handle.
  localparam int TNEW_MAX_W = 8;

  typedef struct packed {
    logic                  regwrite;
    logic [DEF_CTRL_W-1:0] memtoreg;
    logic                  memwrite;
    logic [DEF_DATA_W-1:0] aluout;
    logic [DEF_DATA_W-1:0] writedata;
    logic [DEF_DATA_W-1:0] pc_4;
    logic [DEF_DATA_W-1:0] ext_imm;
    logic [DEF_TNEW_W-1:0] tnew;
    logic [DEF_REG_AW-1:0] a_rs;
    logic [DEF_REG_AW-1:0] a_rt;
    logic [DEF_REG_AW-1:0] awrite;
  } pipe_payload_t;

  localparam pipe_payload_t BUBBLE = '0;

  // Saturating decrement: a result that is already available stays available.
  function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One pipeline register slice: holds on stall, loads a bubble on flush,
// otherwise captures its upstream payload with Tnew decremented by one.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int  TNEW_W    = DEF_TNEW_W,
  parameter type payload_t = pipe_payload_t
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     stall,
  input  logic     flush,
  input  logic     valid_in,
  input  payload_t payload_in,
  output payload_t payload_out,
  output logic     valid
);

  payload_t payload_reg;
  payload_t payload_next;
  logic     valid_reg;
  logic     valid_next;

  always_comb begin
    payload_next      = payload_in;
    payload_next.tnew = TNEW_W'(tnew_dec(TNEW_MAX_W'(payload_in.tnew)));
    valid_next        = valid_in;
    // A bubble is all-zero, so its RegWrite/MemWrite can never fire downstream.
    if (flush) begin
      payload_next = '0;
      valid_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      payload_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (!stall) begin
      payload_reg <= payload_next;
      valid_reg   <= valid_next;
    end
  end

  assign payload_out = payload_reg;
  assign valid       = valid_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-slice pipeline carrying one instruction's fields from stage E toward M/W,
// with stall/flush control, $0-write suppression and per-slice hazard taps.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int TNEW_W = DEF_TNEW_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     RegWriteE,
  input  logic [CTRL_W-1:0]        MemtoRegE,
  input  logic                     MemWriteE,
  input  logic [DATA_W-1:0]        ALUoutE,
  input  logic [DATA_W-1:0]        WriteDataE,
  input  logic [DATA_W-1:0]        PC_4E,
  input  logic [DATA_W-1:0]        ext_immE,
  input  logic [TNEW_W-1:0]        TnewE,
  input  logic [REG_AW-1:0]        A_rsE,
  input  logic [REG_AW-1:0]        A_rtE,
  input  logic [REG_AW-1:0]        AwriteE,
  output logic                     RegWriteM,
  output logic [CTRL_W-1:0]        MemtoRegM,
  output logic                     MemWriteM,
  output logic [DATA_W-1:0]        ALUoutM,
  output logic [DATA_W-1:0]        WriteDataM,
  output logic [DATA_W-1:0]        PC_4M,
  output logic [DATA_W-1:0]        ext_immM,
  output logic [TNEW_W-1:0]        TnewM,
  output logic [REG_AW-1:0]        A_rsM,
  output logic [REG_AW-1:0]        A_rtM,
  output logic [REG_AW-1:0]        AwriteM,
  output logic                     ValidM,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [DEPTH-1:0]         tap_RegWrite,
  output logic [DEPTH*REG_AW-1:0]  tap_Awrite,
  output logic [DEPTH*TNEW_W-1:0]  tap_Tnew
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be in 1..4");
  end
  if (TNEW_W > TNEW_MAX_W) begin : g_bad_tnew_w
    $error("pipe_stage_chain: TNEW_W exceeds TNEW_MAX_W");
  end

  // Same field layout as pipe_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic              regwrite;
    logic [CTRL_W-1:0] memtoreg;
    logic              memwrite;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] pc_4;
    logic [DATA_W-1:0] ext_imm;
    logic [TNEW_W-1:0] tnew;
    logic [REG_AW-1:0] a_rs;
    logic [REG_AW-1:0] a_rt;
    logic [REG_AW-1:0] awrite;
  } slice_t;

  slice_t e_payload;
  slice_t pay_s   [DEPTH];
  logic   valid_s [DEPTH];

  always_comb begin
    e_payload           = '0;
    // Writes to $0 are dropped here so every downstream tap sees the effective enable.
    e_payload.regwrite  = RegWriteE & (AwriteE != '0);
    e_payload.memtoreg  = MemtoRegE;
    e_payload.memwrite  = MemWriteE;
    e_payload.aluout    = ALUoutE;
    e_payload.writedata = WriteDataE;
    e_payload.pc_4      = PC_4E;
    e_payload.ext_imm   = ext_immE;
    e_payload.tnew      = TnewE;
    e_payload.a_rs      = A_rsE;
    e_payload.a_rt      = A_rtE;
    e_payload.awrite    = AwriteE;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
    if (gi == 0) begin : g_head
      pipe_slice #(
        .TNEW_W    (TNEW_W),
        .payload_t (slice_t)
      ) u_slice (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .valid_in    (1'b1),
        .payload_in  (e_payload),
        .payload_out (pay_s[gi]),
        .valid       (valid_s[gi])
      );
    end else begin : g_body
      pipe_slice #(
        .TNEW_W    (TNEW_W),
        .payload_t (slice_t)
      ) u_slice (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (1'b0),
        .valid_in    (valid_s[gi-1]),
        .payload_in  (pay_s[gi-1]),
        .payload_out (pay_s[gi]),
        .valid       (valid_s[gi])
      );
    end

    assign tap_valid[gi]                     = valid_s[gi];
    assign tap_RegWrite[gi]                  = pay_s[gi].regwrite;
    assign tap_Awrite[gi*REG_AW +: REG_AW]   = pay_s[gi].awrite;
    assign tap_Tnew[gi*TNEW_W +: TNEW_W]     = pay_s[gi].tnew;
  end

  assign RegWriteM  = pay_s[DEPTH-1].regwrite;
  assign MemtoRegM  = pay_s[DEPTH-1].memtoreg;
  assign MemWriteM  = pay_s[DEPTH-1].memwrite;
  assign ALUoutM    = pay_s[DEPTH-1].aluout;
  assign WriteDataM = pay_s[DEPTH-1].writedata;
  assign PC_4M      = pay_s[DEPTH-1].pc_4;
  assign ext_immM   = pay_s[DEPTH-1].ext_imm;
  assign TnewM      = pay_s[DEPTH-1].tnew;
  assign A_rsM      = pay_s[DEPTH-1].a_rs;
  assign A_rtM      = pay_s[DEPTH-1].a_rt;
  assign AwriteM    = pay_s[DEPTH-1].awrite;
  assign ValidM     = valid_s[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: a DEPTH=1 and a DEPTH=3 chain share one E-side stimulus stream.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  MemtoRegE;
  logic [31:0] ALUoutE, WriteDataE, PC_4E, ext_immE;
  logic [1:0]  TnewE;
  logic [4:0]  A_rsE, A_rtE, AwriteE;

  // DEPTH=1 outputs
  logic        a_RegWriteM, a_MemWriteM, a_ValidM;
  logic [1:0]  a_MemtoRegM, a_TnewM;
  logic [31:0] a_ALUoutM, a_WriteDataM, a_PC_4M, a_ext_immM;
  logic [4:0]  a_A_rsM, a_A_rtM, a_AwriteM;
  logic [0:0]  a_tap_valid, a_tap_RegWrite;
  logic [4:0]  a_tap_Awrite;
  logic [1:0]  a_tap_Tnew;

  // DEPTH=3 outputs
  logic        b_RegWriteM, b_MemWriteM, b_ValidM;
  logic [1:0]  b_MemtoRegM, b_TnewM;
  logic [31:0] b_ALUoutM, b_WriteDataM, b_PC_4M, b_ext_immM;
  logic [4:0]  b_A_rsM, b_A_rtM, b_AwriteM;
  logic [2:0]  b_tap_valid, b_tap_RegWrite;
  logic [14:0] b_tap_Awrite;
  logic [5:0]  b_tap_Tnew;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUoutE(ALUoutE), .WriteDataE(WriteDataE), .PC_4E(PC_4E), .ext_immE(ext_immE),
    .TnewE(TnewE), .A_rsE(A_rsE), .A_rtE(A_rtE), .AwriteE(AwriteE),
    .RegWriteM(a_RegWriteM), .MemtoRegM(a_MemtoRegM), .MemWriteM(a_MemWriteM),
    .ALUoutM(a_ALUoutM), .WriteDataM(a_WriteDataM), .PC_4M(a_PC_4M), .ext_immM(a_ext_immM),
    .TnewM(a_TnewM), .A_rsM(a_A_rsM), .A_rtM(a_A_rtM), .AwriteM(a_AwriteM),
    .ValidM(a_ValidM), .tap_valid(a_tap_valid), .tap_RegWrite(a_tap_RegWrite),
    .tap_Awrite(a_tap_Awrite), .tap_Tnew(a_tap_Tnew)
  );

  pipe_stage_chain #(.DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUoutE(ALUoutE), .WriteDataE(WriteDataE), .PC_4E(PC_4E), .ext_immE(ext_immE),
    .TnewE(TnewE), .A_rsE(A_rsE), .A_rtE(A_rtE), .AwriteE(AwriteE),
    .RegWriteM(b_RegWriteM), .MemtoRegM(b_MemtoRegM), .MemWriteM(b_MemWriteM),
    .ALUoutM(b_ALUoutM), .WriteDataM(b_WriteDataM), .PC_4M(b_PC_4M), .ext_immM(b_ext_immM),
    .TnewM(b_TnewM), .A_rsM(b_A_rsM), .A_rtM(b_A_rtM), .AwriteM(b_AwriteM),
    .ValidM(b_ValidM), .tap_valid(b_tap_valid), .tap_RegWrite(b_tap_RegWrite),
    .tap_Awrite(b_tap_Awrite), .tap_Tnew(b_tap_Tnew)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_e(input logic [31:0] alu, input logic [1:0] tnew, input logic [4:0] aw,
                       input logic rw, input logic mw);
    ALUoutE    = alu;
    WriteDataE = alu ^ 32'hFFFF_0000;
    PC_4E      = 32'h0040_0004;
    ext_immE   = 32'h0000_00AA;
    TnewE      = tnew;
    AwriteE    = aw;
    RegWriteE  = rw;
    MemWriteE  = mw;
    MemtoRegE  = 2'b01;
    A_rsE      = 5'd1;
    A_rtE      = 5'd2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_e(32'hDEAD_BEEF, 2'd3, 5'd9, 1'b1, 1'b1);
    tick(); tick();
    $display("txn reset: both chains cleared");
    chk("rst_d1_valid",   a_ValidM, 0);
    chk("rst_d1_alu",     a_ALUoutM, 0);
    chk("rst_d1_regw",    a_RegWriteM, 0);
    chk("rst_d1_memw",    a_MemWriteM, 0);
    chk("rst_d1_tnew",    a_TnewM, 0);
    chk("rst_d1_awrite",  a_AwriteM, 0);
    chk("rst_d3_tvalid",  b_tap_valid, 0);
    chk("rst_d3_ttnew",   b_tap_Tnew, 0);
    chk("rst_d3_tawrite", b_tap_Awrite, 0);

    // A: ALUout 0x1234, Tnew 2, Awrite 8, RegWrite 1
    reset = 1'b0;
    set_e(32'h0000_1234, 2'd2, 5'd8, 1'b1, 1'b0);
    tick();
    $display("txn A: alu=0x1234 tnew=2 aw=8");
    chk("A_d1_alu",    a_ALUoutM, 32'h1234);
    chk("A_d1_tnew",   a_TnewM, 1);
    chk("A_d1_awrite", a_AwriteM, 8);
    chk("A_d1_regw",   a_RegWriteM, 1);
    chk("A_d1_valid",  a_ValidM, 1);
    chk("A_d1_wdata",  a_WriteDataM, 32'hFFFF_1234);
    chk("A_d1_mtor",   a_MemtoRegM, 2'b01);
    chk("A_d3_tvalid", b_tap_valid, 3'b001);
    chk("A_d3_ttnew",  b_tap_Tnew, 6'h01);
    chk("A_d3_valid",  b_ValidM, 0);

    // B: write to $0 -> RegWrite suppressed, Tnew 0 stays 0
    set_e(32'h0000_5678, 2'd0, 5'd0, 1'b1, 1'b0);
    tick();
    $display("txn B: alu=0x5678 aw=0 regwrite requested");
    chk("B_d1_alu",     a_ALUoutM, 32'h5678);
    chk("B_d1_regw",    a_RegWriteM, 0);
    chk("B_d1_awrite",  a_AwriteM, 0);
    chk("B_d1_tnew",    a_TnewM, 0);
    chk("B_d3_tvalid",  b_tap_valid, 3'b011);
    chk("B_d3_ttnew",   b_tap_Tnew, 6'h00);
    chk("B_d3_tregw",   b_tap_RegWrite, 3'b010);
    chk("B_d3_tawrite", b_tap_Awrite, 15'h0100);

    // C: A reaches M of the 3-deep chain on this edge
    set_e(32'h0000_9ABC, 2'd3, 5'd31, 1'b1, 1'b1);
    tick();
    $display("txn C: alu=0x9abc tnew=3 aw=31 memwrite");
    chk("C_d1_alu",     a_ALUoutM, 32'h9ABC);
    chk("C_d1_tnew",    a_TnewM, 2);
    chk("C_d1_memw",    a_MemWriteM, 1);
    chk("C_d3_alu",     b_ALUoutM, 32'h1234);
    chk("C_d3_tnew",    b_TnewM, 0);
    chk("C_d3_awrite",  b_AwriteM, 8);
    chk("C_d3_regw",    b_RegWriteM, 1);
    chk("C_d3_valid",   b_ValidM, 1);
    chk("C_d3_tvalid",  b_tap_valid, 3'b111);
    chk("C_d3_ttnew",   b_tap_Tnew, 6'h02);
    chk("C_d3_tawrite", b_tap_Awrite, 15'h201F);
    chk("C_d3_tregw",   b_tap_RegWrite, 3'b101);

    // Stall for 3 edges with new E inputs and flush asserted: nothing moves
    stall = 1'b1; flush = 1'b1;
    set_e(32'h0000_DDDD, 2'd3, 5'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("txn stall cycle %0d with flush", i);
      chk("S_d1_alu",    a_ALUoutM, 32'h9ABC);
      chk("S_d1_tnew",   a_TnewM, 2);
      chk("S_d1_valid",  a_ValidM, 1);
      chk("S_d3_alu",    b_ALUoutM, 32'h1234);
      chk("S_d3_ttnew",  b_tap_Tnew, 6'h02);
      chk("S_d3_tvalid", b_tap_valid, 3'b111);
    end

    // Release: D enters, C->slice1 (tnew 1), B->slice2
    stall = 1'b0; flush = 1'b0;
    tick();
    $display("txn D: alu=0xdddd tnew=3 aw=4 after stall release");
    chk("D_d1_alu",     a_ALUoutM, 32'hDDDD);
    chk("D_d1_tnew",    a_TnewM, 2);
    chk("D_d3_alu",     b_ALUoutM, 32'h5678);
    chk("D_d3_regw",    b_RegWriteM, 0);
    chk("D_d3_ttnew",   b_tap_Tnew, 6'h06);
    chk("D_d3_tawrite", b_tap_Awrite, 15'h03E4);

    // Flush with a valid E instruction: slice 0 becomes a bubble
    flush = 1'b1;
    set_e(32'h0000_FFFF, 2'd1, 5'd5, 1'b1, 1'b1);
    tick();
    $display("txn flush: E instruction dropped");
    chk("F_d1_valid",  a_ValidM, 0);
    chk("F_d1_regw",   a_RegWriteM, 0);
    chk("F_d1_memw",   a_MemWriteM, 0);
    chk("F_d1_alu",    a_ALUoutM, 0);
    chk("F_d3_tvalid", b_tap_valid, 3'b110);
    chk("F_d3_alu",    b_ALUoutM, 32'h9ABC);
    chk("F_d3_memw",   b_MemWriteM, 1);
    chk("F_d3_tnew",   b_TnewM, 0);

    // G fills slice 0 again, then reset mid-flight clears everything
    flush = 1'b0;
    set_e(32'h0000_0777, 2'd2, 5'd7, 1'b1, 1'b0);
    tick();
    $display("txn G: alu=0x777 behind bubble");
    chk("G_d3_tvalid", b_tap_valid, 3'b101);
    chk("G_d3_alu",    b_ALUoutM, 32'hDDDD);

    reset = 1'b1;
    tick();
    $display("txn mid-flight reset");
    chk("R_d3_tvalid",  b_tap_valid, 0);
    chk("R_d3_valid",   b_ValidM, 0);
    chk("R_d3_alu",     b_ALUoutM, 0);
    chk("R_d3_ttnew",   b_tap_Tnew, 0);
    chk("R_d3_tawrite", b_tap_Awrite, 0);
    chk("R_d3_tregw",   b_tap_RegWrite, 0);
    chk("R_d1_valid",   a_ValidM, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
